i3c_fifo_bridge: RTL and testbench
==================================

Name: i3c_fifo_bridge

Overview:
- Parametrised buffering stage between the HCI CSR side and i2c_controller_fsm.
- Queues format entries (byte plus 5 flags) for the controller FSM.
- Packs received bytes into CSR-width words in an RX queue.
- Generates watermark, flush and overflow status.

Parameters:
- FmtFifoDepth, 64, format FIFO entries (power of 2, >=4)
- RxFifoDepth, 64, RX word FIFO entries (power of 2, >=4)
- WordWidth, 32, RX word width in bits; multiple of 8, 8..64; BPW=WordWidth/8
- FmtDepthW (localparam), $clog2(FmtFifoDepth+1), format occupancy width
- RxDepthW (localparam), $clog2(RxFifoDepth+1), RX occupancy width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- fmt_wvalid_i  in  1  format entry write valid
- fmt_wready_o  out  1  format FIFO not full
- fmt_wdata_i  in  13  {nak_ok,read_continue,read_bytes,stop_after,start_before,byte[7:0]}
- fmt_fifo_rvalid_o  out  1  format entry available to FSM
- fmt_fifo_depth_o  out  FmtDepthW  format occupancy
- fmt_fifo_rready_i  in  1  FSM pops head entry
- fmt_byte_o  out  8  head byte
- fmt_flag_start_before_o / fmt_flag_stop_after_o / fmt_flag_read_bytes_o / fmt_flag_read_continue_o / fmt_flag_nak_ok_o  out  1 each  head flags
- rx_fifo_wvalid_i  in  1  byte from FSM
- rx_fifo_wdata_i  in  8  received byte
- host_idle_i  in  1  FSM idle
- rx_rvalid_o  out  1  RX word available
- rx_rready_i  in  1  CSR pops RX word
- rx_rdata_o  out  WordWidth  head RX word
- rx_depth_o  out  RxDepthW  RX occupancy
- fmt_thld_i  in  FmtDepthW  format low watermark
- rx_thld_i  in  RxDepthW  RX high watermark
- fmt_rst_i / rx_rst_i  in  1  synchronous soft clears
- fmt_thld_o / rx_thld_o  out  1  watermark status levels
- rx_flush_o / rx_overflow_o  out  1  one-cycle event pulses

Behaviour:
- Reset values: depths 0; rvalids 0; head data 0; rx_thld_o 0; pulses 0; fmt_wready_o 1; fmt_thld_o 1.
- Handshakes: fmt_wready_o=!full. Push on wvalid&wready. Pop on rvalid&rready.
- Written data is visible at the head the cycle after the push; there is no fall-through.
- Push and pop in the same cycle: depth unchanged.
- Pop while empty is ignored. Push while full is impossible (wready low).
- Pointers are log2(Depth) bits and wrap naturally; full/empty come from the depth counter.
- Head outputs are 0 when empty.
- fmt_thld_o = (fmt_fifo_depth_o <= fmt_thld_i), combinational.
- rx_thld_o = (rx_thld_i!=0) && (rx_depth_o >= rx_thld_i).
- RX packer: lane counter cnt 0..BPW-1 plus a WordWidth accumulator. Little-endian: byte k goes to bits [8k+7:8k].
- Byte when cnt<BPW-1: store, cnt++.
- Byte when cnt==BPW-1: push {byte, accumulator} to the RX FIFO; clear accumulator; cnt=0.
- Flush: host_idle_i rising edge (registered previous value) with cnt>0 pushes the accumulator zero-padded, sets cnt=0 and pulses rx_flush_o.
- Byte and idle-rise in the same cycle: the byte is merged first, then flushed in the same push. If the byte completes the word, a single push occurs and there is no rx_flush_o.
- Word push with the RX FIFO full (after the same-cycle pop is accounted for): word dropped, rx_overflow_o pulses, packer cleared.
- fmt_rst_i: FMT FIFO empty on the next cycle; a same-cycle push is dropped.
- rx_rst_i: RX FIFO and packer cleared; a same-cycle byte and pop are ignored; no pulses that cycle.
- Async reset mid-transfer discards all contents.

Optional Feature:
- Macro: I3C_FIFO_BRIDGE_PACK_EN.
- Defined: packing as described above.
- Undefined: every received byte is pushed immediately as a zero-extended word. cnt and accumulator are absent, rx_flush_o ties to 0, and overflow applies per byte.

Decomposition:
- i3c_pkg gains typedef fmt_entry_t (packed 13-bit struct matching fmt_wdata_i order) and FmtEntryWidth=13.
- RX_FIFO_WIDTH=8 is reused.
- Sub-module i3c_sync_fifo (params Width, Depth; push/pop/clr, depth output) is instantiated twice.

Test Plan:
- Push 64 FMT entries with no pops -> fmt_wready_o=0 at depth 64. 65th push ignored. Pop 64 -> original order, depth 0, rvalid 0.
- fmt_thld_i=4, push 5 -> fmt_thld_o 1 through depth 4, 0 at 5. Pop 1 -> returns to 1.
- PACK_EN, WordWidth=32, bytes 0x11,0x22,0x33,0x44 -> one word 0x44332211, rx_depth_o=1.
- PACK_EN, bytes 0xAA,0xBB then host_idle_i 0->1 -> word 0x0000BBAA, rx_flush_o one pulse. Byte coincident with idle-rise -> merged into the same word.
- RX FIFO full (64 words), complete another word -> rx_overflow_o pulse, depth stays 64, head unchanged. Same case with a concurrent pop -> word accepted, no overflow.
- fmt_rst_i with push at depth 10 -> depth 0 next cycle. rst_ni asserted mid-packing -> all outputs at reset values.

Source files
------------

// File: rtl/i3c_pkg.sv
// rtl/i3c_pkg.sv - shared types and widths for the I3C/I2C host FIFO bridge
package i3c_pkg;

    localparam int FmtEntryWidth = 13;
    localparam int RX_FIFO_WIDTH = 8;

    // Field order matches the fmt_wdata_i bus, MSB first.
    typedef struct packed {
        logic       nak_ok;
        logic       read_continue;
        logic       read_bytes;
        logic       stop_after;
        logic       start_before;
        logic [7:0] data;
    } fmt_entry_t;

endpackage

// File: rtl/i3c_sync_fifo.sv
// rtl/i3c_sync_fifo.sv - single-clock FIFO with occupancy counter and soft clear
module i3c_sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 64,
    localparam int PtrW   = $clog2(Depth),
    localparam int DepthW = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [Width-1:0]  wdata_i,
    input  logic              pop_i,
    output logic [Width-1:0]  rdata_o,
    output logic [DepthW-1:0] depth_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [Width-1:0]  mem [Depth];
    logic [PtrW-1:0]   wptr_q;
    logic [PtrW-1:0]   rptr_q;
    logic [DepthW-1:0] depth_q;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (depth_q == DepthW'(Depth));
    assign empty_o = (depth_q == '0);
    assign pop_ok  = pop_i && !clr_i && !empty_o;
    // A full FIFO can still accept a word when the head leaves in the same cycle.
    assign push_ok = push_i && !clr_i && (!full_o || pop_ok);
    assign depth_o = depth_q;
    assign rdata_o = empty_o ? '0 : mem[rptr_q];

    // Storage array; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally on the power-of-2 depth.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            depth_q <= '0;
        end else if (clr_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            depth_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            if (push_ok && !pop_ok) begin
                depth_q <= depth_q + DepthW'(1);
            end else if (pop_ok && !push_ok) begin
                depth_q <= depth_q - DepthW'(1);
            end
        end
    end

endmodule

// File: rtl/i3c_fifo_bridge.sv
// rtl/i3c_fifo_bridge.sv - format/RX buffering between CSRs and controller FSM (option: I3C_FIFO_BRIDGE_PACK_EN)
module i3c_fifo_bridge
    import i3c_pkg::*;
#(
    parameter int FmtFifoDepth = 64,
    parameter int RxFifoDepth  = 64,
    parameter int WordWidth    = 32,
    localparam int FmtDepthW   = $clog2(FmtFifoDepth + 1),
    localparam int RxDepthW    = $clog2(RxFifoDepth + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     fmt_wvalid_i,
    output logic                     fmt_wready_o,
    input  logic [FmtEntryWidth-1:0] fmt_wdata_i,
    output logic                     fmt_fifo_rvalid_o,
    output logic [FmtDepthW-1:0]     fmt_fifo_depth_o,
    input  logic                     fmt_fifo_rready_i,
    output logic [7:0]               fmt_byte_o,
    output logic                     fmt_flag_start_before_o,
    output logic                     fmt_flag_stop_after_o,
    output logic                     fmt_flag_read_bytes_o,
    output logic                     fmt_flag_read_continue_o,
    output logic                     fmt_flag_nak_ok_o,
    input  logic                     rx_fifo_wvalid_i,
    input  logic [RX_FIFO_WIDTH-1:0] rx_fifo_wdata_i,
    input  logic                     host_idle_i,
    output logic                     rx_rvalid_o,
    input  logic                     rx_rready_i,
    output logic [WordWidth-1:0]     rx_rdata_o,
    output logic [RxDepthW-1:0]      rx_depth_o,
    input  logic [FmtDepthW-1:0]     fmt_thld_i,
    input  logic [RxDepthW-1:0]      rx_thld_i,
    input  logic                     fmt_rst_i,
    input  logic                     rx_rst_i,
    output logic                     fmt_thld_o,
    output logic                     rx_thld_o,
    output logic                     rx_flush_o,
    output logic                     rx_overflow_o
);

    localparam int BPW = WordWidth / 8;

    logic                     fmt_full;
    logic                     fmt_empty;
    logic [FmtEntryWidth-1:0] fmt_head;
    fmt_entry_t               fmt_head_s;

    assign fmt_wready_o      = !fmt_full;
    assign fmt_fifo_rvalid_o = !fmt_empty;

    i3c_sync_fifo #(
        .Width (FmtEntryWidth),
        .Depth (FmtFifoDepth)
    ) u_fmt_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (fmt_rst_i),
        .push_i  (fmt_wvalid_i && !fmt_full),
        .wdata_i (fmt_wdata_i),
        .pop_i   (fmt_fifo_rready_i),
        .rdata_o (fmt_head),
        .depth_o (fmt_fifo_depth_o),
        .full_o  (fmt_full),
        .empty_o (fmt_empty)
    );

    assign fmt_head_s               = fmt_entry_t'(fmt_head);
    assign fmt_byte_o               = fmt_head_s.data;
    assign fmt_flag_start_before_o  = fmt_head_s.start_before;
    assign fmt_flag_stop_after_o    = fmt_head_s.stop_after;
    assign fmt_flag_read_bytes_o    = fmt_head_s.read_bytes;
    assign fmt_flag_read_continue_o = fmt_head_s.read_continue;
    assign fmt_flag_nak_ok_o        = fmt_head_s.nak_ok;
    assign fmt_thld_o               = (fmt_fifo_depth_o <= fmt_thld_i);

    logic                 rx_full;
    logic                 rx_empty;
    logic                 rx_pop;
    logic                 word_push;
    logic                 word_drop;
    logic [WordWidth-1:0] word_data;
    logic                 rx_ovf_q;

    assign rx_pop      = rx_rready_i && !rx_rst_i;
    // A full FIFO is never empty, so a requested pop always frees a slot.
    assign word_drop   = word_push && rx_full && !rx_pop;
    assign rx_rvalid_o = !rx_empty;
    assign rx_thld_o   = (rx_thld_i != '0) && (rx_depth_o >= rx_thld_i);

`ifdef I3C_FIFO_BRIDGE_PACK_EN
    localparam int CntW = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [WordWidth-1:0] acc_q, acc_d;
    logic [WordWidth-1:0] byte_ext;
    logic [WordWidth-1:0] merged;
    logic                 idle_q;
    logic                 idle_rise;
    logic                 byte_v;
    logic                 flush_ev;
    logic                 rx_flush_q;

    assign byte_v    = rx_fifo_wvalid_i && !rx_rst_i;
    assign idle_rise = host_idle_i && !idle_q && !rx_rst_i;

    // Packer: place the byte in its lane, emit full words or flush on idle rise.
    always_comb begin
        byte_ext  = WordWidth'(rx_fifo_wdata_i);
        merged    = acc_q | (byte_ext << {cnt_q, 3'b000});
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        word_push = 1'b0;
        word_data = merged;
        flush_ev  = 1'b0;
        if (rx_rst_i) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (byte_v && (cnt_q == CntW'(BPW - 1))) begin
            word_push = 1'b1;
            cnt_d     = '0;
            acc_d     = '0;
        end else if (byte_v && idle_rise) begin
            word_push = 1'b1;
            flush_ev  = 1'b1;
            cnt_d     = '0;
            acc_d     = '0;
        end else if (byte_v) begin
            cnt_d = cnt_q + CntW'(1);
            acc_d = merged;
        end else if (idle_rise && (cnt_q != '0)) begin
            word_push = 1'b1;
            word_data = acc_q;
            flush_ev  = 1'b1;
            cnt_d     = '0;
            acc_d     = '0;
        end
    end

    // Packer state, idle history and flush pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            idle_q     <= 1'b0;
            rx_flush_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            idle_q     <= host_idle_i;
            rx_flush_q <= flush_ev;
        end
    end

    assign rx_flush_o = rx_flush_q;
`else
    logic unused_host_idle;

    // Without packing, idle has no role: each byte becomes its own word.
    assign unused_host_idle = host_idle_i;
    assign word_push        = rx_fifo_wvalid_i && !rx_rst_i;
    assign word_data        = WordWidth'(rx_fifo_wdata_i);
    assign rx_flush_o       = 1'b0;
`endif

    i3c_sync_fifo #(
        .Width (WordWidth),
        .Depth (RxFifoDepth)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (rx_rst_i),
        .push_i  (word_push),
        .wdata_i (word_data),
        .pop_i   (rx_pop),
        .rdata_o (rx_rdata_o),
        .depth_o (rx_depth_o),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    // Overflow pulse for a word that found no room.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_ovf_q <= 1'b0;
        end else begin
            rx_ovf_q <= word_drop;
        end
    end

    assign rx_overflow_o = rx_ovf_q;

endmodule

// File: tb/tb_i3c_fifo_bridge.sv
// tb/tb_i3c_fifo_bridge.sv - directed checks of the format/RX FIFO bridge
module tb_i3c_fifo_bridge;

    logic        clk;
    logic        rst_n;
    logic        fmt_wvalid;
    logic        fmt_wready;
    logic [12:0] fmt_wdata;
    logic        fmt_rvalid;
    logic [6:0]  fmt_depth;
    logic        fmt_rready;
    logic [7:0]  fmt_byte;
    logic        f_start, f_stop, f_rbytes, f_rcont, f_nak;
    logic        rx_wvalid;
    logic [7:0]  rx_wdata;
    logic        host_idle;
    logic        rx_rvalid;
    logic        rx_rready;
    logic [31:0] rx_rdata;
    logic [6:0]  rx_depth;
    logic [6:0]  fmt_thld;
    logic [6:0]  rx_thld;
    logic        fmt_rst;
    logic        rx_rst;
    logic        fmt_thld_st;
    logic        rx_thld_st;
    logic        rx_flush;
    logic        rx_ovf;

    int checks = 0;
    int errors = 0;

    i3c_fifo_bridge dut (
        .clk_i                    (clk),
        .rst_ni                   (rst_n),
        .fmt_wvalid_i             (fmt_wvalid),
        .fmt_wready_o             (fmt_wready),
        .fmt_wdata_i              (fmt_wdata),
        .fmt_fifo_rvalid_o        (fmt_rvalid),
        .fmt_fifo_depth_o         (fmt_depth),
        .fmt_fifo_rready_i        (fmt_rready),
        .fmt_byte_o               (fmt_byte),
        .fmt_flag_start_before_o  (f_start),
        .fmt_flag_stop_after_o    (f_stop),
        .fmt_flag_read_bytes_o    (f_rbytes),
        .fmt_flag_read_continue_o (f_rcont),
        .fmt_flag_nak_ok_o        (f_nak),
        .rx_fifo_wvalid_i         (rx_wvalid),
        .rx_fifo_wdata_i          (rx_wdata),
        .host_idle_i              (host_idle),
        .rx_rvalid_o              (rx_rvalid),
        .rx_rready_i              (rx_rready),
        .rx_rdata_o               (rx_rdata),
        .rx_depth_o               (rx_depth),
        .fmt_thld_i               (fmt_thld),
        .rx_thld_i                (rx_thld),
        .fmt_rst_i                (fmt_rst),
        .rx_rst_i                 (rx_rst),
        .fmt_thld_o               (fmt_thld_st),
        .rx_thld_o                (rx_thld_st),
        .rx_flush_o               (rx_flush),
        .rx_overflow_o            (rx_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        push;
        logic        pop;
        logic [12:0] wdata;
        logic [6:0]  exp_depth;
        logic        exp_rvalid;
        logic [7:0]  exp_byte;
        logic [4:0]  exp_flags;
        logic        exp_thld;
    } fmt_vec_t;

    fmt_vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic pop);
        rx_wvalid = 1'b1;
        rx_wdata  = b;
        rx_rready = pop;
        step();
        rx_wvalid = 1'b0;
        rx_rready = 1'b0;
    endtask

    task automatic rx_pop_one();
        rx_rready = 1'b1;
        step();
        rx_rready = 1'b0;
    endtask

    function automatic logic [12:0] fmt_head();
        return {f_nak, f_rcont, f_rbytes, f_stop, f_start, fmt_byte};
    endfunction

    initial begin
        rst_n = 1'b0; fmt_wvalid = 1'b0; fmt_wdata = '0; fmt_rready = 1'b0;
        rx_wvalid = 1'b0; rx_wdata = '0; host_idle = 1'b0; rx_rready = 1'b0;
        fmt_thld = 7'd4; rx_thld = 7'd1; fmt_rst = 1'b0; rx_rst = 1'b0;

        vecs[0]  = '{1'b1, 1'b0, 13'h0101, 7'd1, 1'b1, 8'h01, 5'h01, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 13'h0202, 7'd2, 1'b1, 8'h01, 5'h01, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 13'h1F03, 7'd3, 1'b1, 8'h01, 5'h01, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 13'h0004, 7'd4, 1'b1, 8'h01, 5'h01, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 13'h00A5, 7'd5, 1'b1, 8'h01, 5'h01, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 13'h0000, 7'd4, 1'b1, 8'h02, 5'h02, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 13'h0066, 7'd4, 1'b1, 8'h03, 5'h1F, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 13'h0000, 7'd3, 1'b1, 8'h04, 5'h00, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 13'h0000, 7'd2, 1'b1, 8'hA5, 5'h00, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 13'h0000, 7'd1, 1'b1, 8'h66, 5'h00, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 13'h0000, 7'd0, 1'b0, 8'h00, 5'h00, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 13'h0000, 7'd0, 1'b0, 8'h00, 5'h00, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        check("rst_fmt_depth", fmt_depth, 0);
        check("rst_fmt_rvalid", fmt_rvalid, 0);
        check("rst_fmt_head", fmt_head(), 0);
        check("rst_fmt_wready", fmt_wready, 1);
        check("rst_fmt_thld", fmt_thld_st, 1);
        check("rst_rx_depth", rx_depth, 0);
        check("rst_rx_rvalid", rx_rvalid, 0);
        check("rst_rx_rdata", rx_rdata, 0);
        check("rst_rx_thld", rx_thld_st, 0);
        check("rst_flush", rx_flush, 0);
        check("rst_ovf", rx_ovf, 0);
        rst_n = 1'b1;
        step();

        // Format FIFO table: watermark at 4, order, simultaneous push/pop, empty pop
        for (int i = 0; i < 12; i++) begin
            fmt_wvalid = vecs[i].push;
            fmt_rready = vecs[i].pop;
            fmt_wdata  = vecs[i].wdata;
            step();
            check($sformatf("vec%0d_depth", i), fmt_depth, vecs[i].exp_depth);
            check($sformatf("vec%0d_rvalid", i), fmt_rvalid, vecs[i].exp_rvalid);
            check($sformatf("vec%0d_head", i), fmt_head(), {vecs[i].exp_flags, vecs[i].exp_byte});
            check($sformatf("vec%0d_thld", i), fmt_thld_st, vecs[i].exp_thld);
        end
        fmt_wvalid = 1'b0;
        fmt_rready = 1'b0;

        // Fill format FIFO to 64, then an ignored 65th push, then drain in order
        for (int i = 0; i < 64; i++) begin
            fmt_wvalid = 1'b1;
            fmt_wdata  = 13'(i * 37 + 5);
            step();
        end
        check("fill_fmt_depth", fmt_depth, 64);
        check("fill_fmt_wready", fmt_wready, 0);
        check("fill_fmt_thld", fmt_thld_st, 0);
        fmt_wdata = 13'h1ABC;
        step();
        fmt_wvalid = 1'b0;
        check("ovr_fmt_depth", fmt_depth, 64);
        for (int i = 0; i < 64; i++) begin
            check($sformatf("drain%0d_head", i), fmt_head(), 13'(i * 37 + 5));
            fmt_rready = 1'b1;
            step();
            fmt_rready = 1'b0;
        end
        check("drain_fmt_depth", fmt_depth, 0);
        check("drain_fmt_rvalid", fmt_rvalid, 0);
        check("drain_fmt_wready", fmt_wready, 1);

        // Soft clear with a coincident push at depth 10
        for (int i = 0; i < 10; i++) begin
            fmt_wvalid = 1'b1;
            fmt_wdata  = 13'(i + 1);
            step();
        end
        check("pre_clr_depth", fmt_depth, 10);
        fmt_rst = 1'b1;
        fmt_wdata = 13'h0777;
        step();
        fmt_rst = 1'b0;
        fmt_wvalid = 1'b0;
        check("clr_fmt_depth", fmt_depth, 0);
        check("clr_fmt_head", fmt_head(), 0);
        step();
        check("clr_fmt_depth2", fmt_depth, 0);

`ifdef I3C_FIFO_BRIDGE_PACK_EN
        // Packing into a little-endian word
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        check("pack_partial_depth", rx_depth, 0);
        send_byte(8'h44, 1'b0);
        check("pack_depth", rx_depth, 1);
        check("pack_word", rx_rdata, 32'h44332211);
        check("pack_noflush", rx_flush, 0);
        rx_pop_one();
        check("pack_pop_depth", rx_depth, 0);

        // Flush on idle rise
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        host_idle = 1'b1;
        step();
        check("flush_pulse", rx_flush, 1);
        check("flush_word", rx_rdata, 32'h0000BBAA);
        check("flush_depth", rx_depth, 1);
        step();
        check("flush_pulse_end", rx_flush, 0);
        host_idle = 1'b0;
        rx_pop_one();

        // Byte coincident with idle rise merges into the flushed word
        host_idle = 1'b1;
        send_byte(8'hCC, 1'b0);
        check("merge_flush", rx_flush, 1);
        check("merge_word", rx_rdata, 32'h000000CC);
        host_idle = 1'b0;
        rx_pop_one();

        // Completing byte coincident with idle rise: single push, no flush
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        host_idle = 1'b1;
        send_byte(8'h04, 1'b0);
        check("cmpl_idle_depth", rx_depth, 1);
        check("cmpl_idle_word", rx_rdata, 32'h04030201);
        check("cmpl_idle_flush", rx_flush, 0);
        host_idle = 1'b0;
        step();
        check("cmpl_idle_depth2", rx_depth, 1);
`else
        // Unpacked: each byte is a zero-extended word
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        check("byte_depth", rx_depth, 4);
        check("byte_word", rx_rdata, 32'h00000011);
        rx_pop_one();
        check("byte_pop_depth", rx_depth, 3);
        check("byte_pop_word", rx_rdata, 32'h00000022);
        host_idle = 1'b1;
        step();
        check("noflush_pulse", rx_flush, 0);
        check("noflush_depth", rx_depth, 3);
        host_idle = 1'b0;
`endif

        // RX soft clear ignores a coincident byte and pop
        rx_rst = 1'b1;
        rx_wvalid = 1'b1;
        rx_wdata = 8'h99;
        rx_rready = 1'b1;
        step();
        rx_rst = 1'b0;
        rx_wvalid = 1'b0;
        rx_rready = 1'b0;
        check("rxclr_depth", rx_depth, 0);
        check("rxclr_rvalid", rx_rvalid, 0);
        check("rxclr_ovf", rx_ovf, 0);

        // Fill RX FIFO with 64 words
        for (int i = 0; i < 64; i++) begin
`ifdef I3C_FIFO_BRIDGE_PACK_EN
            for (int k = 0; k < 4; k++) send_byte(8'(i + 1), 1'b0);
`else
            send_byte(8'(i + 1), 1'b0);
`endif
        end
        check("rxfull_depth", rx_depth, 64);
        rx_thld = 7'd3;
        #1 check("rxthld_3", rx_thld_st, 1);
        rx_thld = 7'd0;
        #1 check("rxthld_0", rx_thld_st, 0);
        rx_thld = 7'd64;
        #1 check("rxthld_64", rx_thld_st, 1);

        // Overflow without pop, then the same case with a concurrent pop
`ifdef I3C_FIFO_BRIDGE_PACK_EN
        for (int k = 0; k < 3; k++) send_byte(8'hEE, 1'b0);
        check("ovf_pre", rx_ovf, 0);
        send_byte(8'hEE, 1'b0);
        check("ovf_pulse", rx_ovf, 1);
        check("ovf_depth", rx_depth, 64);
        check("ovf_head", rx_rdata, 32'h01010101);
        step();
        check("ovf_pulse_end", rx_ovf, 0);
        for (int k = 0; k < 3; k++) send_byte(8'hEF, 1'b0);
        send_byte(8'hEF, 1'b1);
        check("popovf_pulse", rx_ovf, 0);
        check("popovf_depth", rx_depth, 64);
        check("popovf_head", rx_rdata, 32'h02020202);
`else
        send_byte(8'hEE, 1'b0);
        check("ovf_pulse", rx_ovf, 1);
        check("ovf_depth", rx_depth, 64);
        check("ovf_head", rx_rdata, 32'h00000001);
        step();
        check("ovf_pulse_end", rx_ovf, 0);
        send_byte(8'hEF, 1'b1);
        check("popovf_pulse", rx_ovf, 0);
        check("popovf_depth", rx_depth, 64);
        check("popovf_head", rx_rdata, 32'h00000002);
`endif

        // Async reset mid-transfer
        rx_rst = 1'b1;
        step();
        rx_rst = 1'b0;
        rx_thld = 7'd1;
        fmt_wvalid = 1'b1;
        fmt_wdata = 13'h1234;
        step();
        fmt_wvalid = 1'b0;
        send_byte(8'h5A, 1'b0);
        send_byte(8'h5B, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("arst_fmt_depth", fmt_depth, 0);
        check("arst_fmt_rvalid", fmt_rvalid, 0);
        check("arst_fmt_head", fmt_head(), 0);
        check("arst_fmt_wready", fmt_wready, 1);
        check("arst_rx_depth", rx_depth, 0);
        check("arst_rx_rdata", rx_rdata, 0);
        check("arst_rx_thld", rx_thld_st, 0);
        check("arst_flush", rx_flush, 0);
        check("arst_ovf", rx_ovf, 0);
        #2 rst_n = 1'b1;
        step();
`ifdef I3C_FIFO_BRIDGE_PACK_EN
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        check("post_arst_word", rx_rdata, 32'h04030201);
`else
        send_byte(8'h01, 1'b0);
        check("post_arst_word", rx_rdata, 32'h00000001);
`endif
        check("post_arst_depth", rx_depth, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
